// File: rtl/bank_ch_credit_return_if.sv
// ---------------------------------------------------------------------------
// bank_ch_credit_return_if
// Bundles the channel-side credit-return signals.
//   master : issuing side (issue queue, channel response, downstream ready)
//   slave  : bank_ch_credit_return (buffer, credit pulse, status, errors)
// Signals:
//   issue_vld/issue_tag  credited read issued to this channel, with its tag
//   rsp_vld/rsp_data     read data returned by the channel, in issue order
//   out_vld/out_rdy      oldest-entry handshake toward the read-response path
//   out_tag/out_data     tag and data of the oldest entry
//   credit_release       one-cycle pulse per drained entry
//   credit_used          entries currently allocated
//   err_overflow         sticky: issue while full
//   err_underflow        sticky: response with nothing outstanding
// ---------------------------------------------------------------------------
interface bank_ch_credit_return_if #(
  parameter int CREDIT_NUM = 8,
  parameter int PTR_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
);
  localparam int CW = $clog2(CREDIT_NUM) + 1;

  logic                  issue_vld;
  logic [PTR_WIDTH-1:0]  issue_tag;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  out_vld;
  logic                  out_rdy;
  logic [PTR_WIDTH-1:0]  out_tag;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  credit_release;
  logic [CW-1:0]         credit_used;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output issue_vld, issue_tag, rsp_vld, rsp_data, out_rdy,
    input  out_vld, out_tag, out_data, credit_release, credit_used,
           err_overflow, err_underflow
  );

  modport slave (
    input  issue_vld, issue_tag, rsp_vld, rsp_data, out_rdy,
    output out_vld, out_tag, out_data, credit_release, credit_used,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/bank_ch_credit_return.sv
// ---------------------------------------------------------------------------
// bank_ch_credit_return
// Channel-side end of the bank read-credit protocol. Tracks every credited
// read issued to the channel, captures the in-order read data, delivers
// {tag, data} oldest-first and returns one credit pulse per drained entry.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   ch     bank_ch_credit_return_if.slave (issue, response, output
//          handshake, credit pulse, occupancy, sticky error flags)
// ---------------------------------------------------------------------------
module bank_ch_credit_return #(
  parameter int CREDIT_NUM = 8,
  parameter int PTR_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bank_ch_credit_return_if.slave ch
);
  localparam int AW = $clog2(CREDIT_NUM);
  localparam int CW = AW + 1;

  // Pointers carry an extra wrap bit so full (diff==CREDIT_NUM) and
  // empty (diff==0) are distinguishable.
  logic [CW-1:0]         r_alloc_ptr;
  logic [CW-1:0]         r_fill_ptr;
  logic [CW-1:0]         r_drain_ptr;
  logic                  r_credit_release_p1;
  logic                  r_err_overflow;
  logic                  r_err_underflow;

  // Entry storage is intentionally not reset; the pointers define validity.
  logic [PTR_WIDTH-1:0]  r_tag_mem  [CREDIT_NUM];
  logic [DATA_WIDTH-1:0] r_data_mem [CREDIT_NUM];

  logic [CW-1:0]         w_used;
  logic [CW-1:0]         w_outstanding;
  logic [CW-1:0]         w_ready_cnt;
  logic                  w_full;
  logic                  w_alloc;
  logic                  w_fill;
  logic                  w_out_vld;
  logic                  w_drain;

  always_comb begin
    w_used        = r_alloc_ptr - r_drain_ptr;
    w_outstanding = r_alloc_ptr - r_fill_ptr;
    w_ready_cnt   = r_fill_ptr  - r_drain_ptr;
    // Full comes from registered pointers only: a same-cycle drain does not
    // make room for a same-cycle issue.
    w_full        = (w_used == CW'(CREDIT_NUM));
    w_alloc       = ch.issue_vld & ~w_full;
    // No allocate->fill bypass: a response needs an entry allocated earlier.
    w_fill        = ch.rsp_vld & (w_outstanding != '0);
    w_out_vld     = (w_ready_cnt != '0);
    w_drain       = w_out_vld & ch.out_rdy;
  end

  // ---- stage p0 -> p1: pointer, credit and error state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_ptr         <= '0;
      r_fill_ptr          <= '0;
      r_drain_ptr         <= '0;
      r_credit_release_p1 <= 1'b0;
      r_err_overflow      <= 1'b0;
      r_err_underflow     <= 1'b0;
    end else begin
      if (w_alloc) r_alloc_ptr <= r_alloc_ptr + CW'(1);
      if (w_fill)  r_fill_ptr  <= r_fill_ptr  + CW'(1);
      if (w_drain) r_drain_ptr <= r_drain_ptr + CW'(1);
      r_credit_release_p1 <= w_drain;
      if (ch.issue_vld & w_full)               r_err_overflow  <= 1'b1;
      if (ch.rsp_vld & (w_outstanding == '0))  r_err_underflow <= 1'b1;
    end
  end

  // Tag is captured at allocate, data at fill; the two arrays are written
  // independently so all three pointers can advance in one cycle.
  always_ff @(posedge clk) begin
    if (w_alloc) r_tag_mem[r_alloc_ptr[AW-1:0]] <= ch.issue_tag;
    if (w_fill)  r_data_mem[r_fill_ptr[AW-1:0]] <= ch.rsp_data;
  end

  // Outputs are forced to zero when nothing is ready so reset and idle
  // present clean values regardless of the unreset storage.
  always_comb begin
    ch.out_vld        = w_out_vld;
    ch.out_tag        = w_out_vld ? r_tag_mem[r_drain_ptr[AW-1:0]]  : '0;
    ch.out_data       = w_out_vld ? r_data_mem[r_drain_ptr[AW-1:0]] : '0;
    ch.credit_release = r_credit_release_p1;
    ch.credit_used    = w_used;
    ch.err_overflow   = r_err_overflow;
    ch.err_underflow  = r_err_underflow;
  end
endmodule

// File: tb/tb_bank_ch_credit_return.sv
module tb_bank_ch_credit_return;
  localparam int CN = 8;
  localparam int PW = 8;
  localparam int DW = 64;

  typedef struct packed {
    logic [PW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  bank_ch_credit_return_if #(.CREDIT_NUM(CN), .PTR_WIDTH(PW), .DATA_WIDTH(DW)) bus();

  bank_ch_credit_return #(.CREDIT_NUM(CN), .PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ch    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, owned by the driver process.
  logic [PW-1:0] pend_q[$];   // issued, awaiting data (oldest first)
  ent_t          exp_q[$];    // expected deliveries, in order
  int            acc_total;   // accepted issues since bench start (rebased on reset)
  bit            m_ovf;
  bit            m_unf;
  bit            final_req;

  // Monitor-owned state.
  int            rd_idx;      // next exp_q index to be delivered
  int            drn_total;   // handshakes observed
  bit            hs_now;      // handshake observed this cycle
  bit            exp_rel;     // release pulse expected this cycle
  bit            final_done;
  int            checks;
  int            failures;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle.
  initial begin
    rd_idx = 0; drn_total = 0; hs_now = 0; exp_rel = 0;
    final_done = 0; checks = 0; failures = 0;
  end

  always @(negedge clk) begin
    bit   ev;
    bit   hs;
    ent_t e;
    if (!rst_n) begin
      chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      chk("rst_out_data", bus.out_data, 64'd0);
      chk("rst_release", 64'(bus.credit_release), 64'd0);
      chk("rst_used", 64'(bus.credit_used), 64'd0);
      chk("rst_errs", {62'd0, bus.err_overflow, bus.err_underflow}, 64'd0);
      rd_idx  = exp_q.size();
      exp_rel = 0;
      hs_now  = 0;
    end else begin
      chk("credit_release", 64'(bus.credit_release), 64'(exp_rel));
      chk("credit_used", 64'(bus.credit_used), 64'(acc_total - drn_total));
      chk("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
      chk("err_underflow", 64'(bus.err_underflow), 64'(m_unf));
      ev = (rd_idx < exp_q.size());
      chk("out_vld", 64'(bus.out_vld), 64'(ev));
      if (ev) begin
        e = exp_q[rd_idx];
        chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
        chk("out_data", bus.out_data, e.data);
      end
      hs = ev & bus.out_rdy;
      if (hs) begin
        rd_idx++;
        drn_total++;
      end
      exp_rel = hs;
      hs_now  = hs;
      if (final_req && !final_done) begin
        chk("final_all_delivered", 64'(rd_idx), 64'(exp_q.size()));
        chk("final_used_zero", 64'(bus.credit_used), 64'd0);
        final_done = 1;
      end
    end
  end

  // Model update for one clock edge, using the inputs held during the cycle.
  task automatic model_edge(input logic iv, input logic [PW-1:0] tg,
                            input logic rv, input logic [DW-1:0] d);
    int   used_pre;
    int   outst_pre;
    ent_t e;
    // A drain seen this cycle has not yet freed space at this edge.
    used_pre  = acc_total - drn_total + int'(hs_now);
    outst_pre = pend_q.size();
    if (iv) begin
      if (used_pre >= CN) m_ovf = 1;
      else begin
        pend_q.push_back(tg);
        acc_total++;
      end
    end
    if (rv) begin
      if (outst_pre == 0) m_unf = 1;
      else begin
        e.tag  = pend_q.pop_front();
        e.data = d;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic iv, input logic [PW-1:0] tg,
                     input logic rv, input logic [DW-1:0] d, input logic rdy);
    bus.issue_vld = iv;
    bus.issue_tag = tg;
    bus.rsp_vld   = rv;
    bus.rsp_data  = d;
    bus.out_rdy   = rdy;
    @(posedge clk);
    model_edge(iv, tg, rv, d);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.issue_vld = 1'b0; bus.issue_tag = '0;
    bus.rsp_vld = 1'b0;   bus.rsp_data = '0;
    bus.out_rdy = 1'b0;
    pend_q.delete();
    acc_total = drn_total;
    m_ovf = 0;
    m_unf = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_cycle();
    logic          iv;
    logic          rv;
    logic          rdy;
    logic [PW-1:0] tg;
    logic [DW-1:0] d;
    iv  = ($urandom_range(0, 2) != 0);
    rv  = ((pend_q.size() > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 63) == 0);
    rdy = ($urandom_range(0, 3) != 0);
    tg  = PW'($urandom);
    d   = {$urandom, $urandom};
    cyc(iv, tg, rv, d, rdy);
  endtask

  initial begin
    rst_n = 1'b0;
    acc_total = 0; m_ovf = 0; m_unf = 0; final_req = 0;
    bus.issue_vld = 1'b0; bus.issue_tag = '0;
    bus.rsp_vld = 1'b0;   bus.rsp_data = '0;
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read
    cyc(1'b1, 8'h05, 1'b0, '0, 1'b1);
    idle(2, 1'b1);
    cyc(1'b0, '0, 1'b1, 64'hDEAD, 1'b1);
    idle(4, 1'b1);

    // Fill to full, overflow, then in-order drain
    do_reset();
    for (int i = 0; i < CN; i++) cyc(1'b1, PW'(i), 1'b0, '0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, '0, 1'b0);
    for (int i = 0; i < CN; i++) cyc(1'b0, '0, 1'b1, 64'h1000 + 64'(i), 1'b1);
    idle(4, 1'b1);

    // Backpressure
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, PW'(8'h30 + i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 64'hB0B0_0000 + 64'(i), 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Simultaneous allocate/fill/drain with used=4
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, PW'(8'h40 + i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 64'hC0 + 64'(i), 1'b0);
    cyc(1'b1, 8'h44, 1'b1, 64'hC2, 1'b1);
    cyc(1'b0, '0, 1'b1, 64'hC3, 1'b1);
    cyc(1'b0, '0, 1'b1, 64'hC4, 1'b1);
    idle(4, 1'b1);

    // Wrap: 20 issue/response/drain sequences
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, PW'(8'h60 + i), 1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1, 64'hFACE_0000 + 64'(i), 1'b1);
    end
    idle(3, 1'b1);

    // Underflow, including same-cycle issue + response with none outstanding
    do_reset();
    cyc(1'b0, '0, 1'b1, 64'hBAD, 1'b1);
    cyc(1'b1, 8'h77, 1'b1, 64'hBAD2, 1'b1);
    cyc(1'b0, '0, 1'b1, 64'h7777, 1'b1);
    idle(3, 1'b1);

    // Reset with three live entries
    for (int i = 0; i < 3; i++) cyc(1'b1, PW'(8'h90 + i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 64'h9900 + 64'(i), 1'b0);
    do_reset();
    idle(4, 1'b1);

    // Randomized traffic with one mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      rand_cycle();
    end

    // Flush everything still in flight
    for (int n = 0; n < 40; n++)
      cyc(1'b0, '0, (pend_q.size() > 0), {$urandom, $urandom}, 1'b1);
    idle(3, 1'b1);
    final_req = 1;
    repeat (2) @(negedge clk);
    #1;
    if (!final_done) begin
      failures++;
      $display("FAIL final_check actual=0 required=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bank_ch_credit_return.md
# bank_ch_credit_return

Channel-side end of the bank read-credit protocol. One instance per channel tracks every read the bank issue queue sends to that channel, buffers the read data returned by the channel, and delivers it in order to the bank read-response path. It returns exactly one credit pulse to the bank issue credit manager for each entry drained. Storage depth equals the credit count the manager resets to, so a correctly behaving issuer can never overflow it.

## Interface
- CREDIT_NUM, 8, credits per channel and buffer entries; power of 2, ≥2; must equal the manager's reset credit value
- PTR_WIDTH, 8, width of the issue-queue entry tag carried with each read
- DATA_WIDTH, 64, read data width
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- issue_vld  input  1  a credited read to this channel was issued this cycle
- issue_tag  input  PTR_WIDTH  issue-queue entry index of that read
- rsp_vld  input  1  channel returns read data this cycle (in issue order, no backpressure)
- rsp_data  input  DATA_WIDTH  returned data
- out_vld  output  1  oldest entry holds data
- out_rdy  input  1  downstream accepts
- out_tag  output  PTR_WIDTH  tag of oldest entry
- out_data  output  DATA_WIDTH  data of oldest entry
- credit_release  output  1  one-cycle pulse; one credit returned to manager
- credit_used  output  $clog2(CREDIT_NUM)+1  entries currently allocated
- err_overflow  output  1  sticky: issue_vld while buffer full
- err_underflow  output  1  sticky: rsp_vld with no outstanding read

## Operation
- Storage: CREDIT_NUM entries of {tag, data}, plus three pointers, each $clog2(CREDIT_NUM)+1 bits with a wrap bit: alloc_ptr, fill_ptr, drain_ptr.
- Derived counts use modular pointer subtraction: used = alloc−drain; outstanding = alloc−fill; ready_cnt = fill−drain. Full is used==CREDIT_NUM. Empty is used==0.
- Allocate: issue_vld & ~full writes issue_tag at alloc_ptr and increments alloc_ptr. issue_vld & full drops the request, leaves the pointers unchanged, and sets err_overflow.
- Fill: rsp_vld & outstanding!=0 writes rsp_data at fill_ptr and increments fill_ptr. rsp_vld & outstanding==0 drops the data and sets err_underflow.
- Drain: out_vld = ready_cnt!=0. out_tag/out_data = entry[drain_ptr]. out_vld & out_rdy increments drain_ptr.
- Credit: credit_release is a registered copy of the drain handshake. It is exactly one pulse per drained entry. Total pulses never exceed total accepted issues.
- Simultaneous events:
  - Allocate, fill and drain may all occur in the same cycle, and each pointer moves independently.
  - A drain in the same cycle as an issue while full does not free space for that issue, because full is evaluated on registered state. That issue is dropped and flagged.
  - An issue and a response in the same cycle with outstanding==0: the response is an underflow. There is no same-cycle bypass from allocate to fill.
- Error flags clear only on reset. Errors never corrupt pointers.

## Timing
- Reset (async assert, synchronous-release by the system): pointers 0, out_vld 0, out_tag 0, out_data 0, credit_release 0, credit_used 0, err_* 0. Storage contents are not reset.
- Issue at cycle t: credit_used increments at t+1.
- Response at cycle t to the oldest outstanding entry: out_vld=1 at t+1 with that data. There is no combinational rsp→out path.
- out_vld/out_tag/out_data change only on a handshake or a fill into an empty ready set. They stay stable while out_vld & ~out_rdy.
- Handshake at cycle t: credit_release=1 during t+1, and credit_used decrements at t+1.
- Back-to-back handshakes give consecutive release pulses. Sustained throughput is 1 entry/cycle.
- Reset mid-operation discards all entries and sends no credit pulses. The manager's own reset restores its credits to CREDIT_NUM in the same cycle.
- Wrap-around: pointer low bits wrap at CREDIT_NUM, and the wrap bit distinguishes full from empty.

## Test plan
- Single read: issue tag 0x05 @t0, rsp 0xDEAD @t3, out_rdy=1 -> out_vld @t4 with tag 0x05 and data 0xDEAD; credit_release pulse @t5 only; credit_used 1 from t1 to t4, then 0 @t5.
- Fill to full: 8 issues with tags 0..7 and no responses -> credit_used=8. A 9th issue sets err_overflow and credit_used stays 8. Then 8 responses with out_rdy=1 -> tags 0..7 drain in order and produce 8 release pulses.
- Backpressure: 3 entries filled, out_rdy=0 for 5 cycles -> out_tag/out_data held and no credit_release. Raising out_rdy gives 3 consecutive releases.
- Simultaneous: with used=4, apply issue, response and drain in the same cycle -> alloc, fill and drain pointers each +1; used stays 4; one release on the next cycle.
- Wrap: 20 issue/rsp/drain sequences with CREDIT_NUM=8 -> order preserved across the pointer wrap; never full or empty incorrectly; 20 releases in total.
- Errors/reset: rsp_vld with none outstanding -> err_underflow=1 and out_vld stays 0. Assert rst_n=0 with 3 entries live -> all outputs 0 immediately, and no release pulse after deassertion.
